// File: rtl/mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_arbiter_if
// Purpose : bundles the requester-side and multiplier-side signals of the
//           shared-multiplier arbiter into one interface.
// Modports: slave  - the arbiter (consumes requests, drives the multiplier)
//           master - the environment (requesters plus multiplier model)
// Signals : req/req_a/req_b (requests, packed operands, slice i = requester i)
//           req_ack/res_valid/res_y/res_err (per-requester ack and result)
//           mul_a/mul_b/mul_trigger/mul_resetn (to multiplier)
//           mul_ready/mul_done/mul_y (from multiplier)
// ---------------------------------------------------------------------------
interface mul_arbiter_if #(
  parameter int C_WIDTH = 32,
  parameter int N_REQ   = 4
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*C_WIDTH-1:0] req_a;
  logic [N_REQ*C_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]         req_ack;
  logic [N_REQ-1:0]         res_valid;
  logic [C_WIDTH-1:0]       res_y;
  logic                     res_err;
  logic [C_WIDTH-1:0]       mul_a;
  logic [C_WIDTH-1:0]       mul_b;
  logic                     mul_trigger;
  logic                     mul_ready;
  logic                     mul_done;
  logic [C_WIDTH-1:0]       mul_y;
  logic                     mul_resetn;

  modport slave (
    input  req, req_a, req_b, mul_ready, mul_done, mul_y,
    output req_ack, res_valid, res_y, res_err,
           mul_a, mul_b, mul_trigger, mul_resetn
  );

  modport master (
    output req, req_a, req_b, mul_ready, mul_done, mul_y,
    input  req_ack, res_valid, res_y, res_err,
           mul_a, mul_b, mul_trigger, mul_resetn
  );
endinterface

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Purpose : round-robin arbiter sharing one external multiplier among N_REQ
//           requesters. One multiply is outstanding at a time:
//           IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ports   : ctl_clk - clock, rising edge
//           reset   - synchronous, active-high reset
//           bus     - mul_arbiter_if.slave (requests, results, multiplier)
// Options : MUL_ARB_TIMEOUT_EN - when defined, a multiply that does not
//           complete within 2*C_WIDTH+8 cycles of entering ISSUE is answered
//           with res_y = 0 and res_err = 1. Undefined: res_err is tied to 0
//           and WAIT lasts until mul_done.
// ---------------------------------------------------------------------------
module mul_arbiter #(
  parameter int C_WIDTH = 32,
  parameter int N_REQ   = 4
) (
  input  logic          ctl_clk,
  input  logic          reset,
  mul_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      winner_s;
  logic [N_REQ-1:0]   grant_oh_s;
  logic [C_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [C_WIDTH-1:0] res_y_q, res_y_d;
  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [N_REQ-1:0]   res_valid_q, res_valid_d;
  logic               trigger_s;
  logic [C_WIDTH-1:0] slice_a_s [N_REQ];
  logic [C_WIDTH-1:0] slice_b_s [N_REQ];

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TO_LIMIT = 2 * C_WIDTH + 8;
  localparam int CNT_W    = $clog2(TO_LIMIT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_s;
  logic             res_err_q, res_err_d;
`endif

  // First requester at or after the round-robin pointer, searching upward
  // with wrap-around.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IW-1:0]    ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slice_a_s[g] = bus.req_a[g*C_WIDTH +: C_WIDTH];
    assign slice_b_s[g] = bus.req_b[g*C_WIDTH +: C_WIDTH];
  end

  assign winner_s   = rr_pick(bus.req, ptr_q);
  assign grant_oh_s = N_REQ'(1) << grant_q;
  // Gated by reset so nothing is issued while reset is held.
  assign trigger_s  = (state_q == ISSUE) && bus.mul_ready && !reset;

`ifdef MUL_ARB_TIMEOUT_EN
  assign timeout_s = (cnt_q == CNT_W'(TO_LIMIT - 1));
`endif

  // Next-state, arbitration and datapath capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    res_y_d     = res_y_q;
    req_ack_d   = '0;
    res_valid_d = '0;
`ifdef MUL_ARB_TIMEOUT_EN
    res_err_d   = 1'b0;
    if ((state_q == ISSUE) || (state_q == WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d   = ISSUE;
          grant_d   = winner_s;
          a_d       = slice_a_s[winner_s];
          b_d       = slice_b_s[winner_s];
          req_ack_d = N_REQ'(1) << winner_s;
          ptr_d     = (winner_s == IW'(N_REQ - 1)) ? '0 : winner_s + IW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (trigger_s) begin
          state_d = WAIT;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else if (timeout_s) begin
          state_d     = RESP;
          res_y_d     = '0;
          res_err_d   = 1'b1;
          res_valid_d = grant_oh_s;
        end
`endif
        else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (bus.mul_done) begin
          state_d     = RESP;
          res_y_d     = bus.mul_y;
          res_valid_d = grant_oh_s;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else if (timeout_s) begin
          state_d     = RESP;
          res_y_d     = '0;
          res_err_d   = 1'b1;
          res_valid_d = grant_oh_s;
        end
`endif
        else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        // res_valid_q is high during this state; just return.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_y_q     <= '0;
      req_ack_q   <= '0;
      res_valid_q <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_y_q     <= res_y_d;
      req_ack_q   <= req_ack_d;
      res_valid_q <= res_valid_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_y       = res_y_q;
  assign bus.mul_a       = reset ? '0 : a_q;
  assign bus.mul_b       = reset ? '0 : b_q;
  assign bus.mul_trigger = trigger_s;
  assign bus.mul_resetn  = ~reset;
`ifdef MUL_ARB_TIMEOUT_EN
  assign bus.res_err     = res_err_q;
`else
  assign bus.res_err     = 1'b0;
`endif
endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
// Purpose : directed self-checking bench for mul_arbiter (C_WIDTH=32,
//           N_REQ=4). The bench plays both the requesters and the multiplier.
//           Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;
  localparam int CW = 32;
  localparam int NR = 4;

  logic ctl_clk = 1'b0;
  logic reset   = 1'b1;

  always #5 ctl_clk = ~ctl_clk;

  mul_arbiter_if #(.C_WIDTH(CW), .N_REQ(NR)) bus ();

  logic [CW-1:0] op_a [NR];
  logic [CW-1:0] op_b [NR];

  assign bus.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign bus.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  mul_arbiter #(.C_WIDTH(CW), .N_REQ(NR)) dut (
    .ctl_clk (ctl_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic idle_inputs();
    bus.req       = 4'b0000;
    bus.mul_ready = 1'b1;
    bus.mul_done  = 1'b0;
    bus.mul_y     = 32'd0;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 32'd0;
      op_b[i] = 32'd0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge ctl_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    op_a[0] = 32'd5;
    op_b[0] = 32'd6;
    bus.req = 4'b0001;
    repeat (2) @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ack: got %b expected 0000", bus.req_ack); end
    n_checks++; if (bus.res_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0000", bus.res_valid); end
    n_checks++; if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_err: got %b expected 0", bus.res_err); end
    n_checks++; if (bus.res_y !== 32'd0) begin n_fail++; $display("FAIL reset_res_y: got %h expected 0", bus.res_y); end
    n_checks++; if (bus.mul_trigger !== 1'b0) begin n_fail++; $display("FAIL reset_trigger: got %b expected 0", bus.mul_trigger); end
    n_checks++; if (bus.mul_a !== 32'd0) begin n_fail++; $display("FAIL reset_mul_a: got %h expected 0", bus.mul_a); end
    n_checks++; if (bus.mul_b !== 32'd0) begin n_fail++; $display("FAIL reset_mul_b: got %h expected 0", bus.mul_b); end
    n_checks++; if (bus.mul_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_mul_resetn: got %b expected 0", bus.mul_resetn); end
    bus.req = 4'b0000;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.mul_resetn !== 1'b1) begin n_fail++; $display("FAIL release_mul_resetn: got %b expected 1", bus.mul_resetn); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    op_a[0] = 32'd3;
    op_b[0] = 32'd7;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", bus.req_ack); end
    n_checks++; if (bus.mul_trigger !== 1'b1) begin n_fail++; $display("FAIL single_trigger: got %b expected 1", bus.mul_trigger); end
    n_checks++; if (bus.mul_a !== 32'd3) begin n_fail++; $display("FAIL single_mul_a: got %h expected 3", bus.mul_a); end
    n_checks++; if (bus.mul_b !== 32'd7) begin n_fail++; $display("FAIL single_mul_b: got %h expected 7", bus.mul_b); end
    bus.req = 4'b0000;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 0000", bus.req_ack); end
    n_checks++; if (bus.mul_trigger !== 1'b0) begin n_fail++; $display("FAIL single_trigger_wait: got %b expected 0", bus.mul_trigger); end
    n_checks++; if (bus.mul_a !== 32'd3) begin n_fail++; $display("FAIL single_mul_a_hold: got %h expected 3", bus.mul_a); end
    bus.mul_done = 1'b1;
    bus.mul_y    = 32'd21;
    @(negedge ctl_clk);
    bus.mul_done = 1'b0;
    n_checks++; if (bus.res_valid !== 4'b0001) begin n_fail++; $display("FAIL single_res_valid: got %b expected 0001", bus.res_valid); end
    n_checks++; if (bus.res_y !== 32'd21) begin n_fail++; $display("FAIL single_res_y: got %0d expected 21", bus.res_y); end
    n_checks++; if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL single_res_err: got %b expected 0", bus.res_err); end
    @(negedge ctl_clk);
    n_checks++; if (bus.res_valid !== 4'b0000) begin n_fail++; $display("FAIL single_res_valid_pulse: got %b expected 0000", bus.res_valid); end
    n_checks++; if (bus.res_y !== 32'd21) begin n_fail++; $display("FAIL single_res_y_hold: got %0d expected 21", bus.res_y); end
  endtask

  task automatic test_round_robin();
    int            order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]    exp_ack;
    logic [CW-1:0] exp_y;
    logic          seen;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 32'(i + 1);
      op_b[i] = 32'd10;
    end
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_ack = 4'b0001 << order[g];
      exp_y   = 32'((order[g] + 1) * 10);
      seen    = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge ctl_clk);
        if (bus.req_ack !== 4'b0000) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rr_ack_timeout: grant %0d got no ack expected %b", g, exp_ack); end
      n_checks++; if (bus.req_ack !== exp_ack) begin n_fail++; $display("FAIL rr_order: grant %0d got %b expected %b", g, bus.req_ack, exp_ack); end
      n_checks++; if (bus.mul_a !== 32'(order[g] + 1)) begin n_fail++; $display("FAIL rr_mul_a: grant %0d got %0d expected %0d", g, bus.mul_a, order[g] + 1); end
      @(negedge ctl_clk);
      bus.mul_done = 1'b1;
      bus.mul_y    = exp_y;
      @(negedge ctl_clk);
      bus.mul_done = 1'b0;
      n_checks++; if (bus.res_valid !== exp_ack) begin n_fail++; $display("FAIL rr_res_valid: grant %0d got %b expected %b", g, bus.res_valid, exp_ack); end
      n_checks++; if (bus.res_y !== exp_y) begin n_fail++; $display("FAIL rr_res_y: grant %0d got %0d expected %0d", g, bus.res_y, exp_y); end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_width_wrap();
    logic [CW-1:0] model_y;
    do_reset();
    op_a[0] = 32'hFFFF_FFFF;
    op_b[0] = 32'd2;
    model_y = op_a[0] * op_b[0];
    bus.req = 4'b0001;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b0001) begin n_fail++; $display("FAIL wrap_ack: got %b expected 0001", bus.req_ack); end
    bus.req = 4'b0000;
    @(negedge ctl_clk);
    bus.mul_done = 1'b1;
    bus.mul_y    = model_y;
    @(negedge ctl_clk);
    bus.mul_done = 1'b0;
    n_checks++; if (bus.res_valid !== 4'b0001) begin n_fail++; $display("FAIL wrap_res_valid: got %b expected 0001", bus.res_valid); end
    n_checks++; if (bus.res_y !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_res_y: got %h expected fffffffe", bus.res_y); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mul_ready = 1'b0;
    op_a[1] = 32'd6;
    op_b[1] = 32'd9;
    bus.req = 4'b0010;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b0010) begin n_fail++; $display("FAIL bp_ack: got %b expected 0010", bus.req_ack); end
    n_checks++; if (bus.mul_trigger !== 1'b0) begin n_fail++; $display("FAIL bp_trigger_first: got %b expected 0", bus.mul_trigger); end
    bus.req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge ctl_clk);
      bus.mul_done = 1'b0;
      // A stray completion while still in ISSUE must be ignored.
      if (c == 1) begin
        bus.mul_done = 1'b1;
        bus.mul_y    = 32'hDEAD_BEEF;
      end
      n_checks++; if (bus.mul_trigger !== 1'b0) begin n_fail++; $display("FAIL bp_trigger_stall: cycle %0d got %b expected 0", c, bus.mul_trigger); end
      n_checks++; if (bus.res_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_res_valid_stall: cycle %0d got %b expected 0000", c, bus.res_valid); end
      n_checks++; if (bus.mul_a !== 32'd6) begin n_fail++; $display("FAIL bp_mul_a_hold: cycle %0d got %0d expected 6", c, bus.mul_a); end
    end
    bus.mul_ready = 1'b1;
    #1;
    n_checks++; if (bus.mul_trigger !== 1'b1) begin n_fail++; $display("FAIL bp_trigger_ready: got %b expected 1", bus.mul_trigger); end
    @(negedge ctl_clk);
    n_checks++; if (bus.mul_trigger !== 1'b0) begin n_fail++; $display("FAIL bp_trigger_after: got %b expected 0", bus.mul_trigger); end
    bus.mul_done = 1'b1;
    bus.mul_y    = 32'd54;
    @(negedge ctl_clk);
    bus.mul_done = 1'b0;
    n_checks++; if (bus.res_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_res_valid: got %b expected 0010", bus.res_valid); end
    n_checks++; if (bus.res_y !== 32'd54) begin n_fail++; $display("FAIL bp_res_y: got %h expected 54 decimal", bus.res_y); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    op_a[2] = 32'd4;
    op_b[2] = 32'd5;
    bus.req = 4'b0100;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b0100) begin n_fail++; $display("FAIL rw_ack: got %b expected 0100", bus.req_ack); end
    bus.req = 4'b0000;
    @(negedge ctl_clk);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.mul_a !== 32'd0) begin n_fail++; $display("FAIL rw_mul_a_in_reset: got %h expected 0", bus.mul_a); end
    n_checks++; if (bus.mul_resetn !== 1'b0) begin n_fail++; $display("FAIL rw_mul_resetn: got %b expected 0", bus.mul_resetn); end
    @(negedge ctl_clk);
    reset = 1'b0;
    bus.mul_done = 1'b1;
    bus.mul_y    = 32'd20;
    @(negedge ctl_clk);
    bus.mul_done = 1'b0;
    n_checks++; if (bus.res_valid !== 4'b0000) begin n_fail++; $display("FAIL rw_res_valid: got %b expected 0000", bus.res_valid); end
    @(negedge ctl_clk);
    n_checks++; if (bus.res_valid !== 4'b0000) begin n_fail++; $display("FAIL rw_res_valid_late: got %b expected 0000", bus.res_valid); end
    n_checks++; if (bus.res_y !== 32'd0) begin n_fail++; $display("FAIL rw_res_y: got %h expected 0", bus.res_y); end
    // Pointer must be back at 0: with all requesting, requester 0 wins.
    bus.req = 4'b1111;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b0001) begin n_fail++; $display("FAIL rw_pointer: got %b expected 0001", bus.req_ack); end
    bus.req = 4'b0000;
    @(negedge ctl_clk);
    bus.mul_done = 1'b1;
    bus.mul_y    = 32'd1;
    @(negedge ctl_clk);
    bus.mul_done = 1'b0;
    n_checks++; if (bus.res_valid !== 4'b0001) begin n_fail++; $display("FAIL rw_after_res_valid: got %b expected 0001", bus.res_valid); end
  endtask

`ifdef MUL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cycles;
    do_reset();
    bus.req = 4'b1000;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b1000) begin n_fail++; $display("FAIL to_ack: got %b expected 1000", bus.req_ack); end
    bus.req = 4'b0000;
    cycles = 0;
    for (int c = 0; c < 200 && bus.res_valid === 4'b0000; c++) begin
      @(negedge ctl_clk);
      cycles++;
    end
    n_checks++; if (cycles !== 72) begin n_fail++; $display("FAIL to_cycles: got %0d expected 72", cycles); end
    n_checks++; if (bus.res_valid !== 4'b1000) begin n_fail++; $display("FAIL to_res_valid: got %b expected 1000", bus.res_valid); end
    n_checks++; if (bus.res_err !== 1'b1) begin n_fail++; $display("FAIL to_res_err: got %b expected 1", bus.res_err); end
    n_checks++; if (bus.res_y !== 32'd0) begin n_fail++; $display("FAIL to_res_y: got %h expected 0", bus.res_y); end
    @(negedge ctl_clk);
    n_checks++; if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL to_res_err_pulse: got %b expected 0", bus.res_err); end
  endtask
`else
  task automatic test_no_timeout();
    logic seen;
    do_reset();
    bus.req = 4'b1000;
    @(negedge ctl_clk);
    n_checks++; if (bus.req_ack !== 4'b1000) begin n_fail++; $display("FAIL nto_ack: got %b expected 1000", bus.req_ack); end
    bus.req = 4'b0000;
    seen = 1'b0;
    repeat (150) begin
      @(negedge ctl_clk);
      if (bus.res_valid !== 4'b0000 || bus.res_err !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL nto_spurious_resp: got response expected none"); end
    bus.mul_done = 1'b1;
    bus.mul_y    = 32'd77;
    @(negedge ctl_clk);
    bus.mul_done = 1'b0;
    n_checks++; if (bus.res_valid !== 4'b1000) begin n_fail++; $display("FAIL nto_res_valid: got %b expected 1000", bus.res_valid); end
    n_checks++; if (bus.res_y !== 32'd77) begin n_fail++; $display("FAIL nto_res_y: got %0d expected 77", bus.res_y); end
    n_checks++; if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL nto_res_err: got %b expected 0", bus.res_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_width_wrap();
    test_backpressure();
    test_reset_in_wait();
`ifdef MUL_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end
endmodule
